// File: rtl/bit32_1to3demux_reg_pkg.sv
// Shared definitions for the registered 1-to-3 demux: select encodings,
// default widths and the select-to-target decode.
package bit32_1to3demux_reg_pkg;

  localparam int unsigned DEF_WIDTH = 32;
  localparam int unsigned DEF_CNT_W = 16;
  localparam int unsigned NUM_SLOTS = 3;

  // {sel1, sel2} encodings
  typedef enum logic [1:0] {
    SEL_OUT1  = 2'b00,
    SEL_OUT2  = 2'b01,
    SEL_OUT3  = 2'b10,
    SEL_BCAST = 2'b11
  } sel_e;

  // One-hot (or all-ones for broadcast) target mask; bit 0 = slot 1
  function automatic logic [NUM_SLOTS-1:0] sel_targets(input sel_e sel);
    logic [NUM_SLOTS-1:0] tgt;
    tgt = '0;
    case (sel)
      SEL_OUT1:  tgt = 3'b001;
      SEL_OUT2:  tgt = 3'b010;
      SEL_OUT3:  tgt = 3'b100;
      default:   tgt = 3'b111;
    endcase
    return tgt;
  endfunction

endpackage

// File: rtl/bit32_1to3demux_reg_if.sv
// Producer/consumer bundle for the 1-to-3 demux.
//   in_data/in_valid/in_ready : producer handshake
//   sel1/sel2                 : target select ({sel1,sel2})
//   outN/outN_valid/outN_ready: per-slot consumer handshake
//   accept_count              : accepted-word counter
// slave = the demux, master = the surrounding producer/consumers.
interface bit32_1to3demux_reg_if
  import bit32_1to3demux_reg_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CNT_W = DEF_CNT_W
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             sel1;
  logic             sel2;
  logic [WIDTH-1:0] out1;
  logic [WIDTH-1:0] out2;
  logic [WIDTH-1:0] out3;
  logic             out1_valid;
  logic             out2_valid;
  logic             out3_valid;
  logic             out1_ready;
  logic             out2_ready;
  logic             out3_ready;
  logic [CNT_W-1:0] accept_count;

  modport slave (
    input  in_data, in_valid, sel1, sel2, out1_ready, out2_ready, out3_ready,
    output in_ready, out1, out2, out3, out1_valid, out2_valid, out3_valid,
           accept_count
  );

  modport master (
    output in_data, in_valid, sel1, sel2, out1_ready, out2_ready, out3_ready,
    input  in_ready, out1, out2, out3, out1_valid, out2_valid, out3_valid,
           accept_count
  );
endinterface

// File: rtl/bit32_1to3demux_reg_demux_slot.sv
// One-entry output slot: a data register plus valid flag.
//   clk, reset     : clock, async active-low reset
//   load/load_data : write a new word (only asserted while free)
//   ready          : consumer takes the held word this cycle
//   data/valid     : held word and its valid flag (registered)
//   free           : slot can accept a word this cycle (combinational)
module demux_slot
  import bit32_1to3demux_reg_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             ready,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic             free
);

  // A drain in the same cycle frees the slot for a back-to-back load
  assign free = ~valid | ready;

  // Load wins over drain; data is kept after a drain so it is never X
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data  <= '0;
      valid <= 1'b0;
    end else if (load) begin
      data  <= load_data;
      valid <= 1'b1;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/bit32_1to3demux_reg.sv
// Registered 32-bit 1-to-3 demultiplexer with per-slot valid/ready.
//   clk   : rising-edge clock
//   reset : async active-low reset
//   bus   : producer handshake, select, three slot handshakes, accept counter
module bit32_1to3demux_reg
  import bit32_1to3demux_reg_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic                   clk,
  input  logic                   reset,
  bit32_1to3demux_reg_if.slave   bus
);

  sel_e                 sel;
  logic [NUM_SLOTS-1:0] tgt;
  logic [NUM_SLOTS-1:0] free;
  logic [NUM_SLOTS-1:0] load;
  logic                 accept;
  logic [CNT_W-1:0]     count;

  // Target re-decoded every cycle; nothing is latched
  assign sel = sel_e'({bus.sel1, bus.sel2});
  assign tgt = sel_targets(sel);

  // Ready only when every targeted slot is free
  assign bus.in_ready = &(free | ~tgt);
  assign accept       = bus.in_valid & bus.in_ready;
  assign load         = tgt & {NUM_SLOTS{accept}};

  demux_slot #(.WIDTH(WIDTH)) u_slot1 (
    .clk(clk), .reset(reset), .load(load[0]), .load_data(bus.in_data),
    .ready(bus.out1_ready), .data(bus.out1), .valid(bus.out1_valid),
    .free(free[0])
  );

  demux_slot #(.WIDTH(WIDTH)) u_slot2 (
    .clk(clk), .reset(reset), .load(load[1]), .load_data(bus.in_data),
    .ready(bus.out2_ready), .data(bus.out2), .valid(bus.out2_valid),
    .free(free[1])
  );

  demux_slot #(.WIDTH(WIDTH)) u_slot3 (
    .clk(clk), .reset(reset), .load(load[2]), .load_data(bus.in_data),
    .ready(bus.out3_ready), .data(bus.out3), .valid(bus.out3_valid),
    .free(free[2])
  );

  // Accepted-word counter; a broadcast counts once, wraps naturally
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (accept) begin
      count <= count + CNT_W'(1);
    end
  end

  assign bus.accept_count = count;

endmodule

// File: tb/tb_bit32_1to3demux_reg.sv
module tb_bit32_1to3demux_reg;
  import bit32_1to3demux_reg_pkg::*;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned CNT_W = 4;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  int   cnt;

  bit32_1to3demux_reg_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  bit32_1to3demux_reg #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_count(input string tag);
    chk(tag, 32'(bus.accept_count), 32'(CNT_W'(cnt)));
  endtask

  task automatic set_ready(input logic r1, input logic r2, input logic r3);
    bus.out1_ready = r1;
    bus.out2_ready = r2;
    bus.out3_ready = r3;
  endtask

  task automatic set_sel(input logic [1:0] s);
    bus.sel1 = s[1];
    bus.sel2 = s[0];
  endtask

  initial begin
    total = 0;
    bad   = 0;
    cnt   = 0;

    // Reset held with a valid word pending: nothing may load
    reset        = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = 32'hFFFF_FFFF;
    set_sel(SEL_OUT1);
    set_ready(1'b0, 1'b0, 1'b0);
    repeat (3) step();
    chk("rst_out1", bus.out1, 32'h0);
    chk("rst_out2", bus.out2, 32'h0);
    chk("rst_out3", bus.out3, 32'h0);
    chk("rst_valids", 32'({bus.out1_valid, bus.out2_valid, bus.out3_valid}), 32'h0);
    chk_count("rst_count");
    chk("rst_in_ready", 32'(bus.in_ready), 32'h1);

    // Release between edges; first edge accepts
    reset = 1'b1;
    step();
    cnt++;
    bus.in_valid = 1'b0;
    chk("rel_out1", bus.out1, 32'hFFFF_FFFF);
    chk("rel_out1_valid", 32'(bus.out1_valid), 32'h1);
    chk_count("rel_count");

    // Drain slot 1 without reload: valid clears, data kept
    set_ready(1'b1, 1'b0, 1'b0);
    step();
    set_ready(1'b0, 1'b0, 1'b0);
    chk("drain_out1_valid", 32'(bus.out1_valid), 32'h0);
    chk("drain_out1_keep", bus.out1, 32'hFFFF_FFFF);

    // Steering to slots 2 and 3
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h0000_FFFF;
    set_sel(SEL_OUT2);
    step();
    cnt++;
    bus.in_data = 32'hAAAA_5555;
    set_sel(SEL_OUT3);
    step();
    cnt++;
    bus.in_valid = 1'b0;
    chk("steer_out2", bus.out2, 32'h0000_FFFF);
    chk("steer_out3", bus.out3, 32'hAAAA_5555);
    chk("steer_valids", 32'({bus.out1_valid, bus.out2_valid, bus.out3_valid}), 32'h3);
    chk_count("steer_count");

    // Backpressure on slot 1
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h1111_1111;
    set_sel(SEL_OUT1);
    step();
    cnt++;
    bus.in_data = 32'h2222_2222;
    for (int i = 0; i < 5; i++) begin
      chk("bp_in_ready", 32'(bus.in_ready), 32'h0);
      step();
      chk("bp_out1_hold", bus.out1, 32'h1111_1111);
      chk("bp_valid_hold", 32'(bus.out1_valid), 32'h1);
    end
    // Select changes while stalled are re-decoded: slot 2 is also full
    set_sel(SEL_OUT2);
    #1 chk("bp_resel_in_ready", 32'(bus.in_ready), 32'h0);
    set_sel(SEL_OUT1);
    bus.out1_ready = 1'b1;
    #1 chk("bp_release_in_ready", 32'(bus.in_ready), 32'h1);
    step();
    cnt++;
    bus.in_valid   = 1'b0;
    bus.out1_ready = 1'b0;
    chk("bp_out1_new", bus.out1, 32'h2222_2222);
    chk_count("bp_count");

    // Broadcast blocked by slot 2 only
    set_ready(1'b1, 1'b0, 1'b1);
    step();
    set_ready(1'b0, 1'b0, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h1234_5678;
    set_sel(SEL_BCAST);
    #1 chk("bc_in_ready_blocked", 32'(bus.in_ready), 32'h0);
    step();
    chk_count("bc_count_blocked");
    bus.out2_ready = 1'b1;
    #1 chk("bc_in_ready_open", 32'(bus.in_ready), 32'h1);
    step();
    cnt++;
    bus.in_valid   = 1'b0;
    bus.out2_ready = 1'b0;
    chk("bc_out1", bus.out1, 32'h1234_5678);
    chk("bc_out2", bus.out2, 32'h1234_5678);
    chk("bc_out3", bus.out3, 32'h1234_5678);
    chk("bc_valids", 32'({bus.out1_valid, bus.out2_valid, bus.out3_valid}), 32'h7);
    chk_count("bc_count");

    // Throughput: one word per cycle through slot 1
    set_ready(1'b1, 1'b1, 1'b1);
    step();
    set_ready(1'b1, 1'b0, 1'b0);
    set_sel(SEL_OUT1);
    bus.in_valid = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      bus.in_data = 32'(i);
      #1 chk("tp_in_ready", 32'(bus.in_ready), 32'h1);
      step();
      cnt++;
      chk("tp_out1", bus.out1, 32'(i));
      chk("tp_valid", 32'(bus.out1_valid), 32'h1);
    end
    bus.in_valid = 1'b0;
    step();
    bus.out1_ready = 1'b0;
    chk("tp_drained", 32'(bus.out1_valid), 32'h0);
    // 16 accepts so far: a 4-bit counter has wrapped to 0
    chk("wrap_at_16", 32'(bus.accept_count), 32'h0);

    // 17th accept
    bus.in_valid = 1'b1;
    bus.in_data  = 32'hCAFE_0017;
    set_sel(SEL_OUT2);
    step();
    cnt++;
    bus.in_data = 32'hCAFE_0018;
    set_sel(SEL_OUT3);
    step();
    cnt++;
    bus.in_valid = 1'b0;
    chk("wrap_count", 32'(bus.accept_count), 32'h2);
    chk("pre_arst_valids", 32'({bus.out1_valid, bus.out2_valid, bus.out3_valid}), 32'h3);

    // Async reset between edges
    #2 reset = 1'b0;
    #1;
    cnt = 0;
    chk("arst_valids", 32'({bus.out1_valid, bus.out2_valid, bus.out3_valid}), 32'h0);
    chk("arst_count", 32'(bus.accept_count), 32'h0);
    chk("arst_out2", bus.out2, 32'h0);
    chk("arst_in_ready", 32'(bus.in_ready), 32'h1);

    // First accept on the first edge after release
    @(negedge clk);
    reset        = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h0BAD_F00D;
    set_sel(SEL_OUT1);
    step();
    cnt++;
    bus.in_valid = 1'b0;
    chk("post_arst_out1", bus.out1, 32'h0BAD_F00D);
    chk_count("post_arst_count");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bit32_1to3demux_reg.md
Name: bit32_1to3demux_reg

Overview:
- Registered 32-bit 1-to-3 demultiplexer; the distributing counterpart of the 32-bit 3-to-1 mux used in the datapath.
- Takes one 32-bit word with a valid/ready handshake and steers it into one of three one-entry output slots, or into all three, chosen by {sel1, sel2}.
- Each slot presents its word downstream with its own valid/ready handshake.
- Sits between a single producer (ALU/result bus) and three consumers (e.g. register-file writeback, memory write-data, forwarding path).

Parameters:
- WIDTH, 32, data width of input and each output slot.
- CNT_W, 16, width of the accepted-word counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset; 0 = reset asserted.
- in_data  input  WIDTH  word to distribute.
- in_valid  input  1  producer has a word on in_data.
- in_ready  output  1  block accepts in_data this cycle.
- sel1  input  1  select MSB.
- sel2  input  1  select LSB.
- out1, out2, out3  output  WIDTH  slot data.
- out1_valid, out2_valid, out3_valid  output  1  slot holds a word.
- out1_ready, out2_ready, out3_ready  input  1  consumer takes the slot word this cycle.
- accept_count  output  CNT_W  number of input words accepted since reset.

Behaviour:
- Reset (reset=0, asynchronous): all outN = 0, all outN_valid = 0, accept_count = 0. in_ready follows from the empty slots, so it reads 1 during reset. No acceptance occurs while reset is low.
- Select decode ({sel1, sel2}):
  - 00 -> slot 1.
  - 01 -> slot 2.
  - 10 -> slot 3.
  - 11 -> broadcast to slots 1, 2 and 3.
- Slot free this cycle: outN_valid=0, or (outN_valid=1 and outN_ready=1), i.e. a drain in the same cycle frees the slot.
- in_ready (combinational, no dependence on in_valid):
  - Single target: 1 when the target slot is free.
  - Broadcast: 1 only when all three slots are free.
- Accept = in_valid & in_ready. On the next rising edge each target slot loads in_data and sets outN_valid=1. Latency is 1 cycle from accept to outN_valid.
- Accept and drain on the same edge: the slot holds the new word and valid stays 1, giving full throughput of 1 word/cycle per slot.
- Drain without reload: outN_valid clears on the edge. outN keeps its last value; data while invalid is don't-care but must not be X.
- Hold rule: while outN_valid=1 and outN_ready=0, outN and outN_valid must stay stable.
- Non-target slots are unaffected by an accept and continue their own drain handshakes independently.
- sel1/sel2 may change while in_valid=1 and in_ready=0. The target is re-decoded every cycle; there is no latched selection.
- accept_count increments by 1 per accept (a broadcast counts as 1) and wraps from 2^CNT_W-1 to 0.
- Reset asserted mid-operation: held words are discarded, valids clear immediately and the count clears. On release, the first accept is possible on the first rising edge after reset returns to 1.
- in_valid=0: no slot change except drains; the counter holds.

Decomposition:
- Shared package:
  - Select encodings SEL_OUT1=2'b00, SEL_OUT2=2'b01, SEL_OUT3=2'b10, SEL_BCAST=2'b11.
  - Default WIDTH=32.
- Sub-module demux_slot, instantiated 3 times:
  - Holds one WIDTH-bit register plus a valid flag.
  - Inputs: load, load_data, ready.
  - Outputs: data, valid, free.
- Top level holds the select decode, in_ready logic and accept counter.

Test Plan:
- Reset: hold reset=0 with in_valid=1, in_data=32'hFFFFFFFF, {sel1,sel2}=00. Required: all outN=0, all valid=0, accept_count=0, no load. Release reset and run one edge: out1=32'hFFFFFFFF, out1_valid=1, accept_count=1.
- Steering: send in_data=32'h0000FFFF with sel 01, then 32'hAAAA5555 with sel 10, all outN_ready=0. Required: out2=32'h0000FFFF, out3=32'hAAAA5555, both valid, out1_valid=0, accept_count=2.
- Backpressure: slot 1 full with out1_ready=0, sel 00, in_valid=1. Required: in_ready=0 and out1 unchanged for 5 cycles. Raise out1_ready: in_ready=1 the same cycle, and out1 takes the new word on the next edge.
- Broadcast: sel 11, in_data=32'h12345678, slot 2 full and not draining. Required: in_ready=0. Drain slot 2: the word loads into all three slots on one edge, and accept_count increments by exactly 1.
- Throughput: sel 00, out1_ready=1, in_valid=1 for 10 cycles with data 1..10. Required: in_ready=1 every cycle, out1 shows 1..10 on consecutive cycles, accept_count=10.
- Wrap and async reset: with CNT_W=4, accept 17 words. Required: accept_count=1. Then assert reset between edges: all valids and the count go to 0 immediately, with no clock edge needed.
